// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial receive path.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK
  } rx_state_t;

  localparam logic LINE_IDLE = 1'b1;

  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/serial_sync_fifo.sv
// Synchronous show-ahead FIFO; occupancy count drives full/empty.
module serial_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          empty, do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = empty ? '0 : mem_q[rd_q];
  assign valid_o = !empty;
  assign count_o = cnt_q;

endmodule

// File: rtl/serial_rx_fifo.sv
// UART receiver with start/stop validation feeding a show-ahead FIFO stream.
// Optional parity checking is built when SERIAL_RX_PARITY_EN is defined.
module serial_rx_fifo
  import serial_pkg::*;
#(
  parameter int CLK_HZ     = 24000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
`ifdef SERIAL_RX_PARITY_EN
  , parameter bit ODD_PARITY = 1'b0
`endif
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rx,
  output logic [DATA_BITS-1:0]            data_out,
  output logic                            valid,
  input  logic                            ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            frame_err,
  output logic                            overrun_err,
  output logic                            parity_err
);
  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS+1);

  rx_state_t            state_q, state_d;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic [DCW-1:0]       div_q, div_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 fall, tick, mid, push, fifo_full;

  assign fall = (state_q == IDLE) && rx_prev_q && !rx_s2_q;
  assign tick = (div_q == DCW'(DIV-1));
  assign mid  = tick && (tick_q == TW'(OVERSAMPLE-1));

  // Divider restarts on the start edge so every frame is sampled mid-bit.
  assign div_d = (fall || tick) ? '0 : div_q + DCW'(1);

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    push         = 1'b0;
    if (tick && (state_q == DATA || state_q == PARITY || state_q == STOP))
      tick_d = mid ? '0 : tick_q + TW'(1);
    case (state_q)
      IDLE: if (fall) begin
        state_d   = START;
        tick_d    = '0;
        bit_d     = '0;
        par_bad_d = 1'b0;
      end
      START: if (tick) begin
        if (tick_q == TW'(OVERSAMPLE/2-1)) begin
          tick_d  = '0;
          state_d = rx_s2_q ? IDLE : DATA;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      DATA: if (mid) begin
        shift_d = {rx_s2_q, shift_q[DATA_BITS-1:1]};
        if (bit_q == BW'(DATA_BITS-1)) begin
          bit_d = '0;
`ifdef SERIAL_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: if (mid) begin
        par_bad_d = ^shift_q ^ rx_s2_q ^ ODD_PARITY;
        state_d   = STOP;
      end
`endif
      STOP: if (mid) begin
        if (rx_s2_q != LINE_IDLE) begin
          frame_err_d = 1'b1;
          state_d     = BREAK;
        end else if (bit_q == BW'(STOP_BITS-1)) begin
          state_d      = IDLE;
          parity_err_d = par_bad_q;
          push         = !par_bad_q;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      BREAK: if (rx_s2_q == LINE_IDLE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign overrun_err_d = push && fifo_full && !(valid && ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rx_s1_q       <= LINE_IDLE;
      rx_s2_q       <= LINE_IDLE;
      rx_prev_q     <= LINE_IDLE;
      div_q         <= '0;
      tick_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      par_bad_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_s1_q       <= rx;
      rx_s2_q       <= rx_s1_q;
      rx_prev_q     <= rx_s2_q;
      div_q         <= div_d;
      tick_q        <= tick_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      par_bad_q     <= par_bad_d;
      frame_err_q   <= frame_err_d;
      parity_err_q  <= parity_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  serial_sync_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (ready),
    .rdata_o (data_out),
    .valid_o (valid),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign parity_err  = parity_err_q;

endmodule
